// File: rtl/circuit2_seq_ctrl_pkg.sv
// circuit2_seq_ctrl_pkg
//   Shared definitions for the scheduled Circuit2 datapath:
//   - state_t : controller state encoding (3-bit)
//   - OP_ADD / OP_SUB : op-select values for the shared add/sub unit
package circuit2_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T_D   = 3'd1,
        T_E   = 3'd2,
        T_F   = 3'd3,
        T_OUT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/circuit2_seq_ctrl_addsub.sv
// shared_addsub
//   Single add/sub unit, time-multiplexed by circuit2_seq_ctrl.
//   Modulo 2^DATAWIDTH; carry and borrow are discarded.
// Ports:
//   opa, opb  in   DATAWIDTH  operands
//   op        in   1          OP_ADD (0): opa+opb, OP_SUB (1): opa-opb
//   y         out  DATAWIDTH  result
module shared_addsub
    import circuit2_seq_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] opa,
    input  logic [DATAWIDTH-1:0] opb,
    input  logic                 op,
    output logic [DATAWIDTH-1:0] y
);

    always_comb begin
        if (op == OP_SUB) y = opa - opb;
        else              y = opa + opb;
    end

endmodule

// File: rtl/circuit2_seq_ctrl.sv
// circuit2_seq_ctrl
//   Multi-cycle scheduled Circuit2: d=a+b, e=a+c, f=a-b, g=(d<e)?d:e,
//   h=(d==e)?g:f, x=g<<(d<e), z=h>>(d==e). One shared add/sub unit
//   evaluates d, e and f in successive cycles; start/done handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; a/b/c latched on the accepting edge
//   T_D   | d <= a+b on the shared unit
//   T_E   | e <= a+c on the shared unit
//   T_F   | f <= a-b on the shared unit
//   T_OUT | compare/mux/shift inline, register x and z
//   DONE  | done pulse; start here is accepted like IDLE
//
// Ports:
//   Clk    in   1          clock, rising edge
//   Rst    in   1          asynchronous active-high reset
//   start  in   1          request one evaluation
//   a,b,c  in   DATAWIDTH  operands, captured on the accepting edge
//   busy   out  1          high in every state except IDLE
//   done   out  1          one-cycle pulse when x/z were updated
//   x, z   out  DATAWIDTH  registered results
//
// Build option: CIRCUIT2_SEQ_SIGNED_EN selects signed compare and an
// arithmetic right shift for z; default is unsigned / logical.
module circuit2_seq_ctrl
    import circuit2_seq_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z
);

    state_t state, next_state;

    logic [DATAWIDTH-1:0] a_r, b_r, c_r, d_r, e_r, f_r;
    logic [DATAWIDTH-1:0] au_opb, au_y;
    logic                 au_op;
    logic                 load_in;

    logic                 d_lt_e, d_eq_e;
    logic [DATAWIDTH-1:0] g_val, h_val, x_nxt, z_nxt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        load_in    = 1'b0;
        au_opb     = b_r;
        au_op      = OP_ADD;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load_in    = 1'b1;
                    next_state = T_D;
                end
            end
            T_D:   next_state = T_E;
            T_E: begin
                au_opb     = c_r;
                next_state = T_F;
            end
            T_F: begin
                au_op      = OP_SUB;
                next_state = T_OUT;
            end
            T_OUT: next_state = DONE;
            DONE: begin
                done = 1'b1;
                // Accepting here keeps the 5-cycle cadence when start is held
                // high: the edge leaving DONE is the next accepting edge.
                if (start) begin
                    load_in    = 1'b1;
                    next_state = T_D;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    shared_addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
        .opa (a_r),
        .opb (au_opb),
        .op  (au_op),
        .y   (au_y)
    );

    always_comb begin
        d_eq_e = (d_r == e_r);
`ifdef CIRCUIT2_SEQ_SIGNED_EN
        d_lt_e = ($signed(d_r) < $signed(e_r));
`else
        d_lt_e = (d_r < e_r);
`endif
        g_val = d_lt_e ? d_r : e_r;
        h_val = d_eq_e ? g_val : f_r;
        x_nxt = g_val << d_lt_e;
`ifdef CIRCUIT2_SEQ_SIGNED_EN
        z_nxt = $signed(h_val) >>> d_eq_e;
`else
        z_nxt = h_val >> d_eq_e;
`endif
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
            d_r <= '0;
            e_r <= '0;
            f_r <= '0;
            x   <= '0;
            z   <= '0;
        end else begin
            if (load_in) begin
                a_r <= a;
                b_r <= b;
                c_r <= c;
            end
            case (state)
                T_D:   d_r <= au_y;
                T_E:   e_r <= au_y;
                T_F:   f_r <= au_y;
                T_OUT: begin
                    x <= x_nxt;
                    z <= z_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_circuit2_seq_ctrl.sv
module tb_circuit2_seq_ctrl;

    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] a = '0, b = '0, c = '0;
    logic          busy, done;
    logic [DW-1:0] x, z;

    int n_checks = 0;
    int n_fail   = 0;

    circuit2_seq_ctrl #(.DATAWIDTH(DW)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .z     (z)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One evaluation: start at edge k, done expected after edge k+4 only.
    task automatic run_vec(input string tag, input logic [DW-1:0] va,
                           input logic [DW-1:0] vb, input logic [DW-1:0] vc,
                           input logic [DW-1:0] ex, input logic [DW-1:0] ez);
        @(negedge Clk);
        start = 1'b1; a = va; b = vb; c = vc;
        @(negedge Clk);
        start = 1'b0; a = ~va; b = ~vb; c = ~vc;
        check_val({tag, ".busy_k"}, {31'd0, busy}, 32'd1);
        check_val({tag, ".done_k"}, {31'd0, done}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            check_val({tag, ".done_early"}, {31'd0, done}, 32'd0);
        end
        @(negedge Clk);
        check_val({tag, ".done_k4"}, {31'd0, done}, 32'd1);
        check_val({tag, ".x"}, x, ex);
        check_val({tag, ".z"}, z, ez);
        @(negedge Clk);
        check_val({tag, ".done_k5"}, {31'd0, done}, 32'd0);
        check_val({tag, ".busy_k5"}, {31'd0, busy}, 32'd0);
        check_val({tag, ".x_hold"}, x, ex);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        check_val("rst.busy", {31'd0, busy}, 32'd0);
        check_val("rst.done", {31'd0, done}, 32'd0);
        check_val("rst.x", x, 32'd0);
        check_val("rst.z", z, 32'd0);
        Rst = 1'b0;

        run_vec("T1", 32'd5, 32'd3, 32'd1, 32'd6, 32'd2);
        run_vec("T2", 32'd1, 32'd2, 32'd5, 32'd6, 32'hFFFF_FFFF);
        run_vec("T3", 32'd4, 32'd2, 32'd2, 32'd6, 32'd3);
`ifdef CIRCUIT2_SEQ_SIGNED_EN
        run_vec("T4", 32'hFFFF_FFFE, 32'd0, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFE);
        run_vec("T5", 32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 32'hC000_0000);
`else
        run_vec("T4", 32'hFFFF_FFFE, 32'd0, 32'd3, 32'd1, 32'hFFFF_FFFE);
        run_vec("T5", 32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 32'h4000_0000);
`endif

        // Back-to-back with start held: T1 accepted at k, T2 at k+5.
        @(negedge Clk);
        start = 1'b1; a = 32'd5; b = 32'd3; c = 32'd1;
        @(negedge Clk);
        a = 32'd1; b = 32'd2; c = 32'd5;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            check_val("b2b.done_early1", {31'd0, done}, 32'd0);
        end
        @(negedge Clk);
        check_val("b2b.done1", {31'd0, done}, 32'd1);
        check_val("b2b.x1", x, 32'd6);
        check_val("b2b.z1", z, 32'd2);
        @(negedge Clk);
        start = 1'b0;
        check_val("b2b.busy_k5", {31'd0, busy}, 32'd1);
        check_val("b2b.done_k5", {31'd0, done}, 32'd0);
        for (int i = 6; i <= 8; i++) begin
            @(negedge Clk);
            check_val("b2b.done_early2", {31'd0, done}, 32'd0);
        end
        @(negedge Clk);
        check_val("b2b.done2", {31'd0, done}, 32'd1);
        check_val("b2b.x2", x, 32'd6);
        check_val("b2b.z2", z, 32'hFFFF_FFFF);
        @(negedge Clk);
        check_val("b2b.busy_end", {31'd0, busy}, 32'd0);

        // Reset mid-run: start at k, async reset just after edge k+2.
        @(negedge Clk);
        start = 1'b1; a = 32'd4; b = 32'd2; c = 32'd2;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check_val("rstmid.busy", {31'd0, busy}, 32'd0);
        check_val("rstmid.x", x, 32'd0);
        check_val("rstmid.z", z, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_val("rstmid.no_done", {31'd0, done}, 32'd0);
            check_val("rstmid.idle", {31'd0, busy}, 32'd0);
        end
        run_vec("post_rst", 32'd5, 32'd3, 32'd1, 32'd6, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
